axis_tlp_framer: RTL and testbench

Parametrised successor to the fixed 128-bit FIFO-to-FIFO stream stage in the PCIe datapath. Accepts TLP beats (header beat, then payload beats with per-DW keep mask) through a FIFO write port, buffers them internally, and emits them as an AXI4-Stream master with backpressure. `tlast` and `tkeep` are derived from the header length field, and any mismatch against the supplied mask is flagged. Sits between the TLP builder and the PCIe core TX stream interface.

---
 rtl/axis_tlp_framer.sv | 161 ++++++++++++++++
 tb/tb_axis_tlp_framer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tlp_framer.sv
// TLP beat buffer: FIFO write port in, AXI4-Stream master out. tkeep/tlast
// are rebuilt from the header length field and compared with the supplied mask.
module axis_tlp_framer #(
    parameter int DW_PER_BEAT = 4,
    parameter int DEPTH       = 1024,
    parameter int LEN_W       = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [33*DW_PER_BEAT-1:0]     fifo_datain,
    input  logic                          fifo_wr_en,
    output logic                          fifo_full,
    output logic [$clog2(DEPTH):0]        fifo_data_count,
    output logic [32*DW_PER_BEAT-1:0]     m_axis_tdata,
    output logic [DW_PER_BEAT-1:0]        m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          err_len,
    output logic                          overflow,
    output logic [15:0]                   pkt_count
);

    localparam int DATA_W = 32 * DW_PER_BEAT;
    localparam int W      = 33 * DW_PER_BEAT;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int BL_W   = LEN_W + 1;

    typedef enum logic {
        S_HDR,
        S_PAY
    } state_t;

    logic [W-1:0]             mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic                     fifo_empty;
    logic                     push;
    logic                     load;
    logic                     handshake;
    logic [W-1:0]             rd_word;

    state_t                   state;
    logic [BL_W-1:0]          beats_left;
    logic [DW_PER_BEAT-1:0]   last_keep;
    logic [DW_PER_BEAT-1:0]   sup_mask;

    logic [LEN_W-1:0]         hdr_field;
    logic [BL_W-1:0]          hdr_len;
    logic [BL_W-1:0]          hdr_beats;
    logic [BL_W-1:0]          hdr_rem;
    logic [DW_PER_BEAT-1:0]   hdr_last_keep;

    assign fifo_empty      = (count == '0);
    assign fifo_full       = (count == CW'(DEPTH));
    assign fifo_data_count = count;
    // A write while full is dropped even if the output stage pops this cycle.
    assign push            = fifo_wr_en & ~fifo_full;
    assign handshake       = m_axis_tvalid & m_axis_tready;
    assign load            = ~fifo_empty & (~m_axis_tvalid | m_axis_tready);
    assign rd_word         = mem[rd_ptr];
    assign hdr_field       = rd_word[LEN_W-1:0];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        hdr_len       = {1'b0, hdr_field};
        hdr_last_keep = '0;
        if (hdr_field == '0) begin
            hdr_len = BL_W'(1) << LEN_W;
        end
        hdr_beats = (hdr_len + BL_W'(DW_PER_BEAT - 1)) / BL_W'(DW_PER_BEAT);
        hdr_rem   = hdr_len % BL_W'(DW_PER_BEAT);
        for (int i = 0; i < DW_PER_BEAT; i++) begin
            hdr_last_keep[i] = (hdr_rem == '0) || (BL_W'(i) < hdr_rem);
        end
    end

    // NOTE: the storage array has no reset; only pointers and count need one.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fifo_datain;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (fifo_wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output register plus framing FSM; keep/last are decided when a word loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_HDR;
            beats_left    <= '0;
            last_keep     <= '0;
            sup_mask      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            err_len       <= 1'b0;
            pkt_count     <= '0;
        end else begin
            err_len <= handshake && (sup_mask != m_axis_tkeep);
            if (handshake && m_axis_tlast) begin
                pkt_count <= pkt_count + 16'd1;
            end

            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= rd_word[DATA_W-1:0];
                sup_mask      <= rd_word[W-1:DATA_W];
                case (state)
                    S_HDR: begin
                        m_axis_tkeep <= '1;
                        m_axis_tlast <= 1'b0;
                        beats_left   <= hdr_beats;
                        last_keep    <= hdr_last_keep;
                        state        <= S_PAY;
                    end
                    default: begin
                        beats_left <= beats_left - BL_W'(1);
                        if (beats_left == BL_W'(1)) begin
                            m_axis_tkeep <= last_keep;
                            m_axis_tlast <= 1'b1;
                            state        <= S_HDR;
                        end else begin
                            m_axis_tkeep <= '1;
                            m_axis_tlast <= 1'b0;
                        end
                    end
                endcase
            end else if (handshake) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_tlp_framer.sv
// Randomised scoreboard bench for axis_tlp_framer: stimulus pushes expected
// beats derived from the length rules, a negedge monitor pops and compares.
module tb_axis_tlp_framer;

    localparam int DWB = 4;
    localparam int W   = 33 * DWB;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
        logic         err;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   fifo_datain;
    logic           fifo_wr_en;
    logic           fifo_full;
    logic [6:0]     fifo_data_count;
    logic [127:0]   m_axis_tdata;
    logic [3:0]     m_axis_tkeep;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           m_axis_tlast;
    logic           err_len;
    logic           overflow;
    logic [15:0]    pkt_count;

    logic [W-1:0]   s_datain;
    logic           s_wr_en;
    logic           s_full;
    logic [2:0]     s_count;
    logic [127:0]   s_tdata;
    logic [3:0]     s_tkeep;
    logic           s_tvalid;
    logic           s_tlast;
    logic           s_err;
    logic           s_overflow;
    logic [15:0]    s_pkts;

    int             n_checks = 0;
    int             n_fail   = 0;
    int             rdy_mode = 0;
    beat_t          exp_q[$];
    logic [15:0]    pkts_sent = '0;
    logic [127:0]   last_hdr;

    always #5 clk = ~clk;

    axis_tlp_framer #(.DW_PER_BEAT(DWB), .DEPTH(64), .LEN_W(10)) dut (
        .clk(clk), .reset(rst),
        .fifo_datain(fifo_datain), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .fifo_data_count(fifo_data_count),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .err_len(err_len),
        .overflow(overflow), .pkt_count(pkt_count)
    );

    axis_tlp_framer #(.DW_PER_BEAT(DWB), .DEPTH(4), .LEN_W(10)) dut_small (
        .clk(clk), .reset(rst),
        .fifo_datain(s_datain), .fifo_wr_en(s_wr_en),
        .fifo_full(s_full), .fifo_data_count(s_count),
        .m_axis_tdata(s_tdata), .m_axis_tkeep(s_tkeep),
        .m_axis_tvalid(s_tvalid), .m_axis_tready(1'b0),
        .m_axis_tlast(s_tlast), .err_len(s_err),
        .overflow(s_overflow), .pkt_count(s_pkts)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: err_len refers to the handshake seen one negedge earlier.
    initial begin
        logic        pending_err;
        logic [15:0] model_pkts;
        beat_t       e;
        pending_err = 1'b0;
        model_pkts  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                pending_err = 1'b0;
                model_pkts  = '0;
            end else begin
                check("err_len", err_len, pending_err);
                check("pkt_count_track", pkt_count, model_pkts);
                pending_err = 1'b0;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got tdata %0h expected no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", m_axis_tdata, e.data);
                        check("tkeep", m_axis_tkeep, e.keep);
                        check("tlast", m_axis_tlast, e.last);
                        pending_err = e.err;
                        if (e.last) model_pkts = model_pkts + 16'd1;
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [127:0] data, input logic [3:0] mask, input int gap);
        int k;
        if (gap > 0) begin
            repeat ($urandom_range(0, gap)) begin
                @(posedge clk);
                #1;
            end
        end
        k = 0;
        while (fifo_full && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (fifo_full) begin
            $display("FAIL full_wait: got fifo_full 1 expected 0 within 5000 cycles");
            $fatal(1, "stuck full");
        end
        fifo_datain = {mask, data};
        fifo_wr_en  = 1'b1;
        @(posedge clk);
        #1;
        fifo_wr_en  = 1'b0;
    endtask

    // Expected beats follow directly from L: ceil(L/4) payload beats, last keep = L mod 4.
    task automatic send_packet(input int len, input int bad_idx, input logic [3:0] bad_xor, input int gap);
        int           beats;
        int           rem;
        logic [127:0] d;
        logic [3:0]   ek;
        logic [3:0]   mask;
        beat_t        e;
        beats = (len + 3) / 4;
        rem   = len % 4;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[9:0] = 10'(len);
        last_hdr = d;
        mask = 4'hf;
        if (bad_idx == 0) mask = mask ^ bad_xor;
        e.data = d; e.keep = 4'hf; e.last = 1'b0; e.err = (mask != 4'hf);
        exp_q.push_back(e);
        write_word(d, mask, gap);
        for (int b = 0; b < beats; b++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            ek = 4'hf;
            if (b == beats - 1 && rem != 0) ek = 4'hf >> (4 - rem);
            mask = ek;
            if (bad_idx == b + 1) mask = mask ^ bad_xor;
            e.data = d; e.keep = ek; e.last = (b == beats - 1); e.err = (mask != ek);
            exp_q.push_back(e);
            write_word(d, mask, gap);
        end
        pkts_sent = pkts_sent + 16'd1;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_remaining", 128'(exp_q.size()), 128'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_fifo_full", fifo_full, 1'b0);
        check("rst_count", fifo_data_count, 7'd0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tkeep", m_axis_tkeep, 4'd0);
        check("rst_tdata", m_axis_tdata, 128'd0);
        check("rst_err_len", err_len, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_pkt_count", pkt_count, 16'd0);
    endtask

    initial begin
        logic [127:0] stall_hdr;
        int           gaps;
        int           len;
        int           bad;
        rst = 1'b1;
        fifo_datain = '0;
        fifo_wr_en  = 1'b0;
        s_datain    = '0;
        s_wr_en     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        rdy_mode = 1;
        @(posedge clk);
        #1;

        // Directed packets from the length rules, including a wrong supplied mask.
        send_packet(4, -1, 4'h0, 0);
        send_packet(2, -1, 4'h0, 0);
        send_packet(6, -1, 4'h0, 0);
        send_packet(10, -1, 4'h0, 0);
        send_packet(4, 1, 4'b1100, 0);
        wait_drain(200);
        check("pkt_count_directed", pkt_count, pkts_sent);

        // Stall: 6 packets / 16 words with tready low, then release.
        rdy_mode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_packet(4, -1, 4'h0, 0);
        stall_hdr = last_hdr;
        send_packet(4, -1, 4'h0, 0);
        send_packet(4, -1, 4'h0, 0);
        send_packet(8, -1, 4'h0, 0);
        send_packet(8, -1, 4'h0, 0);
        send_packet(12, -1, 4'h0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_count", fifo_data_count, 7'd15);
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_tdata", m_axis_tdata, stall_hdr);
        repeat (3) @(negedge clk);
        check("stall_tdata_hold", m_axis_tdata, stall_hdr);
        check("stall_tlast_hold", m_axis_tlast, 1'b0);
        rdy_mode = 1;
        @(posedge clk);
        #2;
        gaps = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!m_axis_tvalid) gaps++;
        end
        check("stall_bubbles", 128'(gaps), 128'd0);
        check("stall_count_end", fifo_data_count, 7'd0);
        @(negedge clk);
        check("stall_tvalid_end", m_axis_tvalid, 1'b0);
        check("stall_pkt_count", pkt_count, pkts_sent);
        wait_drain(50);

        // Random lengths, random backpressure and gaps, occasional wrong masks.
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            len = (p == 7) ? 1024 : $urandom_range(1, 48);
            bad = -1;
            if ($urandom_range(0, 5) == 0) bad = $urandom_range(0, (len + 3) / 4);
            send_packet(len, bad, 4'($urandom_range(1, 15)), 2);
        end
        rdy_mode = 1;
        wait_drain(5000);
        check("pkt_count_random", pkt_count, pkts_sent);
        check("overflow_clear", overflow, 1'b0);

        // Reset in the middle of an L=10 packet, then an L=2 packet.
        rdy_mode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        write_word({118'd0, 10'd10}, 4'hf, 0);
        write_word(128'h1234, 4'hf, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("async_rst_tvalid", m_axis_tvalid, 1'b0);
        check("async_rst_count", fifo_data_count, 7'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pkts_sent = '0;
        check_reset_values();
        rdy_mode = 1;
        @(posedge clk);
        #1;
        send_packet(2, -1, 4'h0, 0);
        wait_drain(100);
        check("pkt_count_after_reset", pkt_count, 16'd1);

        // DEPTH=4 instance with tready low: fill, then overflow on the sixth write.
        for (int i = 0; i < 6; i++) begin
            s_datain = {4'hf, 128'(32'ha0 + i)};
            s_wr_en  = 1'b1;
            @(posedge clk);
            #1;
            if (i == 4) begin
                check("small_full", s_full, 1'b1);
                check("small_count_full", s_count, 3'd4);
                check("small_no_overflow", s_overflow, 1'b0);
            end
        end
        s_wr_en = 1'b0;
        check("small_overflow", s_overflow, 1'b1);
        check("small_count_kept", s_count, 3'd4);
        repeat (3) @(posedge clk);
        #1;
        check("small_overflow_sticky", s_overflow, 1'b1);
        check("small_tvalid", s_tvalid, 1'b1);
        check("small_tdata", s_tdata, 128'h0a0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
